// File: rtl/instr_sequencer_if.sv
// Handshake and status bundle between an instruction source / function register
// and instr_sequencer. The sequencer takes the slave side.
interface instr_sequencer_if #(
    parameter int COUNT_W = 8
);
    logic               instr_valid;
    logic [11:0]        instr;
    logic               done;
    logic               instr_ready;
    logic [4:0]         T;
    logic [2:0]         opcode;
    logic [2:0]         p1;
    logic [2:0]         p2;
    logic [2:0]         p3;
    logic               busy;
    logic               illegal;
    logic               fault;
    logic [COUNT_W-1:0] retired;

    modport master (
        output instr_valid, instr, done,
        input  instr_ready, T, opcode, p1, p2, p3, busy, illegal, fault, retired
    );

    modport slave (
        input  instr_valid, instr, done,
        output instr_ready, T, opcode, p1, p2, p3, busy, illegal, fault, retired
    );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: accepts opcodes 0-4, walks a one-hot step strobe until done.
// Define INSTR_SEQ_WATCHDOG_EN to abort instructions that overrun step T[4] and flag fault.
module instr_sequencer #(
    parameter int COUNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    instr_sequencer_if.slave bus
);
    typedef enum logic {IDLE, EXEC} state_e;

    state_e             state_q, state_d;
    logic [4:0]         t_q, t_d;
    logic [11:0]        fields_q, fields_d;
    logic               illegal_q, illegal_d;
    logic [COUNT_W-1:0] retired_q, retired_d;
`ifdef INSTR_SEQ_WATCHDOG_EN
    logic               fault_q, fault_d;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            t_q       <= '0;
            fields_q  <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
`ifdef INSTR_SEQ_WATCHDOG_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            fields_q  <= fields_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
`ifdef INSTR_SEQ_WATCHDOG_EN
            fault_q   <= fault_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        fields_d  = fields_q;
        illegal_d = 1'b0;
        retired_d = retired_q;
`ifdef INSTR_SEQ_WATCHDOG_EN
        fault_d   = fault_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    if (bus.instr[11:9] <= 3'd4) begin
                        state_d  = EXEC;
                        t_d      = 5'b00001;
                        fields_d = bus.instr;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                // done takes priority over the last-step watchdog
                if (bus.done) begin
                    state_d   = IDLE;
                    t_d       = '0;
                    retired_d = retired_q + COUNT_W'(1);
                end else if (t_q[4]) begin
`ifdef INSTR_SEQ_WATCHDOG_EN
                    state_d = IDLE;
                    t_d     = '0;
                    fault_d = 1'b1;
`else
                    t_d     = t_q;
`endif
                end else begin
                    t_d = t_q << 1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.instr_ready = (state_q == IDLE);
    assign bus.busy        = (state_q == EXEC);
    assign bus.T           = t_q;
    assign bus.opcode      = fields_q[11:9];
    assign bus.p1          = fields_q[8:6];
    assign bus.p2          = fields_q[5:3];
    assign bus.p3          = fields_q[2:0];
    assign bus.illegal     = illegal_q;
    assign bus.retired     = retired_q;
`ifdef INSTR_SEQ_WATCHDOG_EN
    assign bus.fault       = fault_q;
`else
    assign bus.fault       = 1'b0;
`endif
endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized self-checking bench for instr_sequencer; expectations come from a
// per-instruction model (step count, latched fields, modulo retire count, sticky fault).
module tb_instr_sequencer;
    localparam int CW = 2;
    localparam int VW = 21 + CW;

    logic clock;
    logic reset;

    instr_sequencer_if #(.COUNT_W(CW)) bus ();

    instr_sequencer #(.COUNT_W(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [11:0]   m_fields;
    logic [CW-1:0] m_ret;
    logic          m_fault;

    // {ready, busy, illegal, fault, T, opcode, p1, p2, p3, retired}
    function automatic logic [VW-1:0] obs();
        return {bus.instr_ready, bus.busy, bus.illegal, bus.fault, bus.T,
                bus.opcode, bus.p1, bus.p2, bus.p3, bus.retired};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Offer one instruction; k = step index at which done is raised (>=5 means late/never).
    task automatic exec_instr(input logic [11:0] ins, input int k, input bit hold);
        logic [4:0]    exp_t;
        logic [VW-1:0] exp_v;
        bit            fin;
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        step();
        if (ins[11:9] > 3'd4) begin
            bus.instr_valid = 1'b0;
            exp_v = {1'b1, 1'b0, 1'b1, m_fault, 5'b0, m_fields, m_ret};
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL illegal_pulse: got %h expected %h", obs(), exp_v);
            end
            step();
            exp_v = {1'b1, 1'b0, 1'b0, m_fault, 5'b0, m_fields, m_ret};
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL illegal_clear: got %h expected %h", obs(), exp_v);
            end
            return;
        end
        m_fields = ins;
        fin = 1'b0;
        for (int j = 0; j <= k && !fin; j++) begin
            exp_t = (j < 4) ? 5'(1 << j) : 5'b10000;
            if (!hold) begin
                bus.instr_valid = 1'($urandom);
                bus.instr       = 12'($urandom);
            end
            exp_v = {1'b0, 1'b1, 1'b0, m_fault, exp_t, m_fields, m_ret};
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL exec_step%0d: got %h expected %h", j, obs(), exp_v);
            end
            if (j == k) begin
                bus.done = 1'b1;
                step();
                bus.done = 1'b0;
                m_ret++;
                fin = 1'b1;
            end else begin
                step();
`ifdef INSTR_SEQ_WATCHDOG_EN
                if (j == 4) begin
                    m_fault = 1'b1;
                    fin = 1'b1;
                end
`endif
            end
        end
        if (!hold) bus.instr_valid = 1'b0;
        exp_v = {1'b1, 1'b0, 1'b0, m_fault, 5'b0, m_fields, m_ret};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL exec_end: got %h expected %h", obs(), exp_v);
        end
    endtask

    task automatic test_reset();
        logic [11:0]   ins;
        logic [VW-1:0] exp_v;
        ins = 12'b010_101_110_111;
        reset = 1'b0;
        bus.done = 1'b0;
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        repeat (3) step();
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 5'b0, 12'b0, {CW{1'b0}}};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs(), exp_v);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL reset_release_no_accept: got %h expected %h", obs(), exp_v);
        end
        step();
        exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 5'b00001, ins, {CW{1'b0}}};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL first_accept: got %h expected %h", obs(), exp_v);
        end
        bus.instr_valid = 1'b0;
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        m_fields = ins;
        m_ret = CW'(1);
        m_fault = 1'b0;
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 5'b0, m_fields, m_ret};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL done_at_T0: got %h expected %h", obs(), exp_v);
        end
    endtask

    task automatic test_load();
        exec_instr(12'b001_011_000_000, 1, 1'b0);
        checks++;
        if (bus.p1 !== 3'd3) begin
            errors++;
            $display("FAIL load_p1: got %0d expected 3", bus.p1);
        end
    endtask

    task automatic test_add();
        exec_instr(12'b011_001_010_011, 3, 1'b0);
        checks++;
        if ({bus.p2, bus.p3} !== {3'd2, 3'd3}) begin
            errors++;
            $display("FAIL add_p2p3: got %h expected %h", {bus.p2, bus.p3}, {3'd2, 3'd3});
        end
    endtask

    task automatic test_illegal();
        exec_instr(12'b110_111_111_111, 0, 1'b0);
        exec_instr(12'b101_000_000_001, 0, 1'b0);
    endtask

    task automatic test_done_idle();
        logic [VW-1:0] exp_v;
        bus.done = 1'b1;
        repeat (3) begin
            step();
            exp_v = {1'b1, 1'b0, 1'b0, m_fault, 5'b0, m_fields, m_ret};
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL done_in_idle: got %h expected %h", obs(), exp_v);
            end
        end
        bus.done = 1'b0;
    endtask

    task automatic test_watchdog();
        exec_instr(12'b000_010_001_100, 8, 1'b0);
        exec_instr(12'b100_001_001_001, 4, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            exec_instr({3'($urandom_range(0, 7)), 9'($urandom)}, $urandom_range(0, 7), 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] exp_v;
        bus.instr = 12'b010_011_100_101;
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        step();
        step();
        checks++;
        if (bus.T !== 5'b00100) begin
            errors++;
            $display("FAIL pre_reset_T: got %b expected 00100", bus.T);
        end
        #1 reset = 1'b0;
        #1;
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 5'b0, 12'b0, {CW{1'b0}}};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL async_reset_mid: got %h expected %h", obs(), exp_v);
        end
        #4 reset = 1'b1;
        m_fields = '0;
        m_ret = '0;
        m_fault = 1'b0;
        step();
    endtask

    task automatic test_wrap();
        logic [11:0] ins;
        reset = 1'b0;
        #2 reset = 1'b1;
        m_fields = '0;
        m_ret = '0;
        m_fault = 1'b0;
        step();
        ins = {3'($urandom_range(0, 4)), 9'($urandom)};
        for (int i = 0; i < 5; i++) exec_instr(ins, $urandom_range(0, 4), 1'b1);
        bus.instr_valid = 1'b0;
        checks++;
        if (bus.retired !== CW'(1)) begin
            errors++;
            $display("FAIL wrap_retired: got %0d expected 1", bus.retired);
        end
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        bus.done = 1'b0;
        m_fields = '0;
        m_ret = '0;
        m_fault = 1'b0;
        test_reset();
        test_load();
        test_add();
        test_illegal();
        test_done_idle();
        test_watchdog();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
